// File: rtl/rtu_pkg.sv
// Shared types and helpers for the Modbus RTU frame receiver.
package rtu_pkg;

  // One-hot receiver states.
  typedef enum logic [4:0] {
    StInit    = 5'b00001,
    StIdle    = 5'b00010,
    StRecv    = 5'b00100,
    StEmit    = 5'b01000,
    StDiscard = 5'b10000
  } rtu_state_e;

  localparam logic [15:0] CRC_POLY  = 16'hA001;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;
  localparam int unsigned FRAME_MAX = 256;

  // CRC-16/Modbus, reflected, one whole byte per call.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/rtu_frame_rx_if.sv
// Byte input, frame status and buffer read port of the RTU frame receiver.
interface rtu_frame_rx_if;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_drop_byte;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic [8:0] frame_len;
  logic       crc_ok;
  logic       frame_err;
  logic       frame_busy;

  // Byte source and frame consumer side.
  modport master (
    output rx_done, rx_data, rx_drop_byte, rd_addr,
    input  rd_data, frame_valid, frame_len, crc_ok, frame_err, frame_busy
  );

  // Receiver side.
  modport slave (
    input  rx_done, rx_data, rx_drop_byte, rd_addr,
    output rd_data, frame_valid, frame_len, crc_ok, frame_err, frame_busy
  );
endinterface

// File: rtl/rtu_frame_buf.sv
// 256x8 frame buffer: single write port, registered read port (block RAM friendly).
module rtu_frame_buf
  import rtu_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [FRAME_MAX];
  logic [7:0] rd_data_q;

  // Write port; contents are not reset.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register; a same-cycle write to rd_addr is seen on the next read.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rd_data_q <= '0;
    else           rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/rtu_frame_rx.sv
// Modbus RTU frame assembler: buffers bytes, delimits frames by 3.5-char silence,
// discards corrupt or oversized frames and checks the CRC residue.
module rtu_frame_rx
  import rtu_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input logic          clk_in,
  input logic          rst_n_in,
  rtu_frame_rx_if.slave bus
);

  localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int unsigned T35_CYCLES = BIT_CYCLES * 77 / 2;
  localparam logic [23:0] T35        = 24'(T35_CYCLES);

  rtu_state_e  state_q;
  logic [23:0] timer_q;
  logic [8:0]  len_q;
  logic [15:0] crc_q;
  logic        frame_valid_q;
  logic        frame_err_q;
  logic        crc_ok_q;
  logic [8:0]  frame_len_q;

  logic        silence;
  logic        take_byte;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  rd_data;
  logic [15:0] crc_next;

  assign silence   = (timer_q == T35);
  // A drop pulse overrides a byte arriving in the same cycle.
  assign take_byte = bus.rx_done && !bus.rx_drop_byte;

  // Line silence timer: cleared by every byte, saturates at T35.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)        timer_q <= '0;
    else if (bus.rx_done) timer_q <= '0;
    else if (!silence)    timer_q <= timer_q + 24'd1;
  end

  // Buffer write strobe and running CRC for the incoming byte.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = len_q[7:0];
    crc_next = crc16_byte((state_q == StIdle) ? CRC_INIT : crc_q, bus.rx_data);
    if (state_q == StIdle && take_byte) begin
      wr_en   = 1'b1;
      wr_addr = 8'd0;
    end else if (state_q == StRecv && take_byte && len_q != 9'(FRAME_MAX)) begin
      wr_en = 1'b1;
    end
  end

  // Frame FSM with registered status outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= StInit;
      len_q         <= '0;
      crc_q         <= CRC_INIT;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      crc_ok_q      <= 1'b0;
      frame_len_q   <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      unique case (state_q)
        StInit: begin
          if (silence && !bus.rx_done) state_q <= StIdle;
        end
        StIdle: begin
          if (bus.rx_done) begin
            if (bus.rx_drop_byte) begin
              state_q <= StDiscard;
            end else begin
              len_q   <= 9'd1;
              crc_q   <= crc_next;
              state_q <= StRecv;
            end
          end
        end
        StRecv: begin
          if (bus.rx_drop_byte) begin
            state_q <= StDiscard;
          end else if (bus.rx_done) begin
            if (len_q == 9'(FRAME_MAX)) begin
              state_q <= StDiscard;
            end else begin
              len_q <= len_q + 9'd1;
              crc_q <= crc_next;
            end
          end else if (silence) begin
            state_q       <= StEmit;
            frame_valid_q <= 1'b1;
            frame_len_q   <= len_q;
            crc_ok_q      <= (crc_q == 16'h0000) && (len_q >= 9'd4);
          end
        end
        StEmit: begin
          state_q <= StIdle;
        end
        StDiscard: begin
          if (silence && !bus.rx_done) begin
            frame_err_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  rtu_frame_buf u_buf (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (bus.rx_data),
    .rd_addr  (bus.rd_addr),
    .rd_data  (rd_data)
  );

  assign bus.rd_data     = rd_data;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.crc_ok      = crc_ok_q;
  assign bus.frame_busy  = (state_q == StRecv);

endmodule

// File: tb/tb_rtu_frame_rx.sv
// Self-checking bench for rtu_frame_rx: frame-level reference model plus directed cases.
module tb_rtu_frame_rx;

  localparam int unsigned CLK_FREQ  = 5000000;
  localparam int unsigned BAUD_RATE = 115200;
  localparam int          T35       = int'((CLK_FREQ / BAUD_RATE) * 77 / 2);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rtu_frame_rx_if bus ();

  rtu_frame_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial CRC over a whole frame, reflected 0xA001, init 0xFFFF.
  function automatic logic [15:0] crc_over(input logic [7:0] b[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (b[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  // ---------------- reference model (evaluated at each rising edge) ----------------
  typedef enum int {PhStartup, PhIdle, PhColl, PhEmit, PhDisc} ph_e;

  ph_e        ph;
  int         quiet;
  logic [7:0] frame_q[$];
  logic [7:0] mem_m [256];
  logic       known [256];
  logic       exp_valid, exp_err, exp_busy, exp_ok, exp_rd_known;
  logic [8:0] exp_len;
  logic [7:0] exp_rd;

  initial begin : model
    logic       sil, d, dr;
    logic [7:0] dat, a;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        ph = PhStartup;
        quiet = 0;
        frame_q.delete();
        foreach (known[i]) known[i] = 1'b0;
        exp_valid = 0; exp_err = 0; exp_busy = 0; exp_ok = 0; exp_len = '0;
        exp_rd = '0; exp_rd_known = 1'b1;
      end else begin
        sil = (quiet >= T35);
        d   = bus.rx_done;
        dr  = bus.rx_drop_byte;
        dat = bus.rx_data;
        a   = bus.rd_addr;
        exp_rd       = mem_m[a];
        exp_rd_known = known[a];
        exp_valid = 0;
        exp_err   = 0;
        case (ph)
          PhStartup: if (sil && !d) ph = PhIdle;
          PhIdle: begin
            if (d) begin
              if (dr) ph = PhDisc;
              else begin
                frame_q.delete();
                frame_q.push_back(dat);
                mem_m[0] = dat; known[0] = 1'b1;
                ph = PhColl;
              end
            end
          end
          PhColl: begin
            if (dr) ph = PhDisc;
            else if (d) begin
              if (frame_q.size() == 256) ph = PhDisc;
              else begin
                mem_m[frame_q.size()] = dat;
                known[frame_q.size()] = 1'b1;
                frame_q.push_back(dat);
              end
            end else if (sil) begin
              exp_valid = 1;
              exp_len   = 9'(frame_q.size());
              exp_ok    = (crc_over(frame_q) == 16'h0000) && (frame_q.size() >= 4);
              ph = PhEmit;
            end
          end
          PhEmit: ph = PhIdle;
          PhDisc: if (sil && !d) begin exp_err = 1; ph = PhIdle; end
          default: ph = PhStartup;
        endcase
        exp_busy = (ph == PhColl);
        if (d) quiet = 0;
        else if (quiet < T35) quiet++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("rst_frame_err",   32'(bus.frame_err),   32'd0);
        check("rst_frame_busy",  32'(bus.frame_busy),  32'd0);
        check("rst_frame_len",   32'(bus.frame_len),   32'd0);
        check("rst_crc_ok",      32'(bus.crc_ok),      32'd0);
        check("rst_rd_data",     32'(bus.rd_data),     32'd0);
      end else begin
        check("frame_valid", 32'(bus.frame_valid), 32'(exp_valid));
        check("frame_err",   32'(bus.frame_err),   32'(exp_err));
        check("frame_busy",  32'(bus.frame_busy),  32'(exp_busy));
        check("frame_len",   32'(bus.frame_len),   32'(exp_len));
        check("crc_ok",      32'(bus.crc_ok),      32'(exp_ok));
        if (exp_rd_known) check("rd_data", 32'(bus.rd_data), 32'(exp_rd));
      end
    end
  end

  // ---------------- stimulus helpers (enter and leave 1 time unit after a rising edge) ----------------
  task automatic drive_cycle(input logic done, input logic [7:0] data, input logic drop,
                             input int addr);
    bus.rx_done      = done;
    bus.rx_data      = data;
    bus.rx_drop_byte = drop;
    bus.rd_addr      = (addr < 0) ? 8'($urandom) : 8'(addr);
    @(posedge clk);
    #1;
    bus.rx_done      = 1'b0;
    bus.rx_drop_byte = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, 1'b0, -1);
  endtask

  task automatic send(input logic [7:0] b[$]);
    foreach (b[i]) drive_cycle(1'b1, b[i], 1'b0, -1);
  endtask

  task automatic watch(input int cycles, output int nv, output int ne, output int lat_v,
                       output int lat_e);
    nv = 0; ne = 0; lat_v = -1; lat_e = -1;
    for (int i = 1; i <= cycles; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b0, -1);
      if (bus.frame_valid) begin nv++; if (lat_v < 0) lat_v = i; end
      if (bus.frame_err)   begin ne++; if (lat_e < 0) lat_e = i; end
    end
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] good[$];
  logic [7:0] bad[$];
  logic [7:0] tmp[$];
  logic [7:0] rnd[$];
  int nv, ne, lv, le;

  initial begin : stim
    good = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    bad  = good;
    bad[7] = 8'h0B;
    bus.rx_done = 1'b0; bus.rx_data = '0; bus.rx_drop_byte = 1'b0; bus.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Startup: bytes before the first silence are ignored.
    idle(20);
    send(good);
    watch(T35 + 20, nv, ne, lv, le);
    check("startup_no_valid", 32'(nv), 32'd0);
    check("startup_no_err",   32'(ne), 32'd0);

    // Good frame, timing and readback.
    send(good);
    watch(T35 + 20, nv, ne, lv, le);
    check("good_valid_cnt", 32'(nv), 32'd1);
    check("good_latency",   32'(lv), 32'(T35 + 1));
    check("good_len",       32'(bus.frame_len), 32'd8);
    check("good_crc_ok",    32'(bus.crc_ok), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b0, i);
      check("readback", 32'(bus.rd_data), 32'(good[i]));
    end

    // Bad CRC.
    send(bad);
    watch(T35 + 20, nv, ne, lv, le);
    check("bad_valid_cnt", 32'(nv), 32'd1);
    check("bad_len",       32'(bus.frame_len), 32'd8);
    check("bad_crc_ok",    32'(bus.crc_ok), 32'd0);

    // Gap violation after byte 3.
    tmp = good[0:2];
    send(tmp);
    drive_cycle(1'b0, 8'h00, 1'b1, -1);
    tmp = good[3:7];
    send(tmp);
    watch(T35 + 20, nv, ne, lv, le);
    check("gap_no_valid", 32'(nv), 32'd0);
    check("gap_err_cnt",  32'(ne), 32'd1);
    check("gap_err_lat",  32'(le), 32'(T35 + 1));

    // Overflow, then recovery.
    for (int i = 0; i < 257; i++) drive_cycle(1'b1, 8'($urandom), 1'b0, -1);
    watch(T35 + 20, nv, ne, lv, le);
    check("ovf_no_valid", 32'(nv), 32'd0);
    check("ovf_err_cnt",  32'(ne), 32'd1);
    send(good);
    watch(T35 + 20, nv, ne, lv, le);
    check("post_ovf_valid", 32'(nv), 32'd1);
    check("post_ovf_ok",    32'(bus.crc_ok), 32'd1);

    // Drop and byte in the same cycle.
    tmp = good[0:1];
    send(tmp);
    drive_cycle(1'b1, 8'h00, 1'b1, -1);
    tmp = good[3:7];
    send(tmp);
    watch(T35 + 20, nv, ne, lv, le);
    check("simul_no_valid", 32'(nv), 32'd0);
    check("simul_err_cnt",  32'(ne), 32'd1);

    // Byte arriving exactly when the timer reaches T35 continues the frame.
    tmp = good[0:2];
    send(tmp);
    idle(T35);
    tmp = good[3:7];
    send(tmp);
    watch(T35 + 20, nv, ne, lv, le);
    check("edge_valid_cnt", 32'(nv), 32'd1);
    check("edge_len",       32'(bus.frame_len), 32'd8);
    check("edge_crc_ok",    32'(bus.crc_ok), 32'd1);

    // Three-byte frame with a correct CRC is still too short.
    tmp = '{8'h01, 8'h7E, 8'h80};
    send(tmp);
    watch(T35 + 20, nv, ne, lv, le);
    check("short_valid_cnt", 32'(nv), 32'd1);
    check("short_len",       32'(bus.frame_len), 32'd3);
    check("short_crc_ok",    32'(bus.crc_ok), 32'd0);

    // Randomised frames: content, length, byte gaps, CRC validity and drops.
    for (int f = 0; f < 14; f++) begin
      int len, dpos;
      logic [15:0] c;
      len = int'($urandom_range(1, 24));
      rnd.delete();
      for (int i = 0; i < len; i++) rnd.push_back(8'($urandom));
      if (len >= 3 && $urandom_range(0, 1) == 1) begin
        tmp = rnd[0:len-3];
        c = crc_over(tmp);
        rnd[len-2] = c[7:0];
        rnd[len-1] = c[15:8];
      end
      dpos = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      for (int i = 0; i < len; i++) begin
        idle(int'($urandom_range(0, 3)));
        if (i == dpos && $urandom_range(0, 1) == 1) begin
          drive_cycle(1'b1, rnd[i], 1'b1, -1);
        end else begin
          drive_cycle(1'b1, rnd[i], 1'b0, -1);
          if (i == dpos) drive_cycle(1'b0, 8'h00, 1'b1, -1);
        end
      end
      idle(T35 + 3 + int'($urandom_range(0, 20)));
    end

    // Reset mid-frame abandons the frame silently.
    tmp = good[0:3];
    send(tmp);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    watch(T35 + 20, nv, ne, lv, le);
    check("rst_mid_no_valid", 32'(nv), 32'd0);
    check("rst_mid_no_err",   32'(ne), 32'd0);
    send(good);
    watch(T35 + 20, nv, ne, lv, le);
    check("post_rst_valid", 32'(nv), 32'd1);
    check("post_rst_ok",    32'(bus.crc_ok), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rtu_frame_rx.md
Name: rtu_frame_rx

Overview:
- Frame assembler downstream of uart_byte_rx and ct_1t_gen in the Modbus RTU slave.
- Collects received bytes into a 256-byte frame buffer and delimits frames by 3.5-character line silence.
- Discards frames flagged by rx_drop_byte (inter-character gap violation) and checks CRC-16/Modbus.
- Presents the completed frame to the protocol decoder through a registered read port.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, line baud rate
- Derived constant BIT_CYCLES = CLK_FREQ/BAUD_RATE.
- Derived constant T35_CYCLES = BIT_CYCLES*77/2 (38.5 bit times); 16709 at the defaults.
- The silence counter is 24 bits wide.

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset, asynchronous, active low
rx_done  input  1  one-cycle pulse; rx_data is valid in the same cycle
rx_data  input  8  received byte
rx_drop_byte  input  1  one-cycle pulse from ct_1t_gen; current frame is corrupt
rd_addr  input  8  frame buffer read index
rd_data  output  8  buffer[rd_addr], registered, 1-cycle latency
frame_valid  output  1  one-cycle pulse; frame complete
frame_len  output  9  byte count of the last frame, range 1..256
crc_ok  output  1  CRC residue is 0 and frame_len >= 4; valid while frame_valid is high and held afterwards
frame_err  output  1  one-cycle pulse; frame discarded
frame_busy  output  1  high in state RECV

Behaviour:
- Reset (asynchronous, active low):
  - state = INIT, counters cleared, crc = 16'hFFFF.
  - All outputs are 0, including rd_data and frame_len.
  - Buffer contents are undefined.
  - Reset mid-frame abandons the frame with no frame_valid and no frame_err.
- Silence timer:
  - Cleared on every rx_done; otherwise increments, saturating at T35_CYCLES.
  - "Silence" means the timer equals T35_CYCLES.
- State INIT: wait for silence (rx_done restarts the timer), then go to IDLE. Bytes received in INIT are ignored.
- State IDLE: on rx_done:
  - store the byte at index 0, len = 1, crc = update(16'hFFFF, byte);
  - go to RECV.
- State RECV:
  - rx_done: store at index len, len += 1, update crc.
  - rx_done when len == 256: overflow; go to DISCARD.
  - rx_drop_byte: go to DISCARD.
  - Silence: go to EMIT.
- State EMIT (1 cycle):
  - frame_valid = 1; frame_len = len; crc_ok = (crc == 0) && (len >= 4).
  - Next state is IDLE.
- State DISCARD:
  - Stays until silence; rx_done bytes are not stored and restart the timer.
  - On silence, pulse frame_err for 1 cycle and go to IDLE.
- Simultaneous events:
  - rx_drop_byte with rx_done in the same cycle: drop wins and the byte is not stored.
  - rx_done in the same cycle the timer reaches T35: the byte wins and the timer clears.
- CRC: reflected polynomial 16'hA001, init 16'hFFFF, byte-wide combinational update, low CRC byte transmitted first. The residue over data plus CRC is 0.
- Buffer:
  - Single-port write, independent read.
  - Not locked: a new frame overwrites it, so the consumer must read before the next frame starts (frame_busy rises).
  - A read of the index being written in the same cycle returns the old data.
- frame_len and crc_ok hold until the next EMIT.

Decomposition:
- Package rtu_pkg:
  - state encodings (one-hot: INIT, IDLE, RECV, EMIT, DISCARD);
  - CRC_POLY 16'hA001 and CRC_INIT 16'hFFFF;
  - FRAME_MAX 256;
  - function crc16_byte(crc, byte).
- Sub-module rtu_frame_buf: 256x8 RAM with a registered read port, so it infers block RAM.

Test Plan:
- Startup: after reset, send 01 03 00 00 00 01 84 0A within 100 cycles of reset release. Required: no frame_valid (INIT still waiting for silence), then IDLE after T35.
- Good frame: after silence, send 01 03 00 00 00 01 84 0A back-to-back. Required:
  - 16709 cycles after the last rx_done: frame_valid pulse, frame_len = 8, crc_ok = 1;
  - reads at rd_addr 0..7 return the same bytes with 1-cycle latency.
- Bad CRC: same frame with last byte 0B. Required: frame_valid with frame_len = 8, crc_ok = 0.
- Gap violation: pulse rx_drop_byte after byte 3. Required: no frame_valid; frame_err pulses once, T35 after the last rx_done.
- Overflow: 257 bytes without a gap. Required: frame_err, no frame_valid. Then a valid 8-byte frame is accepted normally.
- Boundaries:
  - rx_done and rx_drop_byte in the same cycle: DISCARD.
  - rx_done exactly at timer = T35: no EMIT, frame continues, frame_len is incremented.
  - 3-byte frame with correct CRC for 1 data byte: crc_ok = 0.
